// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX core among NREQ byte requesters, with burst lock,
// inter-frame gap and a busy timeout. Define UART_ARB_PRIO_EN for fixed-priority arbitration.
module uart_tx_arbiter #(
    parameter int NREQ        = 4,
    parameter int DW          = 8,
    parameter int GAP_CYC     = 1250,
    parameter int TIMEOUT_CYC = 4096,
    localparam int GW         = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ-1:0]    req_last,
    output logic [NREQ-1:0]    req_ready,
    output logic               tx_start,
    output logic [DW-1:0]      tx_data,
    input  logic               tx_busy,
    input  logic               tx_done,
    output logic               grant_valid,
    output logic [GW-1:0]      grant_id,
    output logic               arb_idle,
    output logic               err_timeout,
    input  logic               err_clr,
    output logic [2:0]         state_dbg
);

    localparam int CMAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST = (GAP_CYC == 0) ? '0 : CW'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_GAP       = 3'd4
    } state_t;

    state_t          state, state_n;
    logic [GW-1:0]   rr_ptr, rr_ptr_n;
    logic            tx_start_n;
    logic [DW-1:0]   tx_data_n;
    logic            grant_valid_n;
    logic [GW-1:0]   grant_id_n;
    logic            err_n;
    logic [CW-1:0]   cnt, cnt_n, cnt_inc;
    logic            last_q, last_n;
    logic            in_burst, burst_n;
    logic            win_found;
    logic [GW-1:0]   win_id;
    logic [GW-1:0]   next_ptr;
    logic            gap_over;

    // Search upward from rr_ptr with wraparound; rr_ptr stays 0 in priority mode.
    always_comb begin
        int unsigned idx;
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = GW'(idx);
            end
        end
    end

`ifdef UART_ARB_PRIO_EN
    assign next_ptr = '0;
`else
    assign next_ptr = (int'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;
`endif

    assign cnt_inc   = (cnt == '1) ? cnt : cnt + 1'b1;
    assign arb_idle  = (state == S_IDLE);
    assign state_dbg = state;

    // Handshake: req_ready[i] is high only in LOAD for the granted requester; a byte is
    // transferred on any clock edge where req_valid[i] && req_ready[i].
    always_comb begin
        state_n       = state;
        rr_ptr_n      = rr_ptr;
        tx_start_n    = 1'b0;
        tx_data_n     = tx_data;
        grant_valid_n = grant_valid;
        grant_id_n    = grant_id;
        err_n         = err_timeout & ~err_clr;
        cnt_n         = cnt;
        last_n        = last_q;
        burst_n       = in_burst;
        req_ready     = '0;
        gap_over      = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (win_found) begin
                    grant_id_n    = win_id;
                    grant_valid_n = 1'b1;
                    burst_n       = 1'b0;
                    cnt_n         = '0;
                    state_n       = S_LOAD;
                end
            end
            S_LOAD: begin
                req_ready[grant_id] = 1'b1;
                if (req_valid[grant_id]) begin
                    tx_data_n  = req_data[grant_id*DW +: DW];
                    tx_start_n = 1'b1;
                    last_n     = req_last[grant_id];
                    cnt_n      = '0;
                    state_n    = S_WAIT_BUSY;
                end else if (!in_burst) begin
                    grant_valid_n = 1'b0;
                    state_n       = S_IDLE;
                end else if (cnt == TO_LAST) begin
                    // Requester stalled mid-burst: give the transmitter to others.
                    grant_valid_n = 1'b0;
                    rr_ptr_n      = next_ptr;
                    state_n       = S_IDLE;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_n = S_WAIT_DONE;
                end else if (cnt == TO_LAST) begin
                    err_n         = 1'b1;
                    grant_valid_n = 1'b0;
                    rr_ptr_n      = next_ptr;
                    state_n       = S_IDLE;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            S_WAIT_DONE: begin
                if (tx_done || !tx_busy) begin
                    cnt_n = '0;
                    if (GAP_CYC == 0) gap_over = 1'b1;
                    else              state_n  = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt == GAP_LAST) gap_over = 1'b1;
                else                 cnt_n    = cnt_inc;
            end
            default: state_n = S_IDLE;
        endcase

        if (gap_over) begin
            cnt_n = '0;
            if (!last_q) begin
                burst_n = 1'b1;
                state_n = S_LOAD;
            end else begin
                grant_valid_n = 1'b0;
                rr_ptr_n      = next_ptr;
                state_n       = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            err_timeout <= 1'b0;
            cnt         <= '0;
            last_q      <= 1'b0;
            in_burst    <= 1'b0;
        end else begin
            state       <= state_n;
            rr_ptr      <= rr_ptr_n;
            tx_start    <= tx_start_n;
            tx_data     <= tx_data_n;
            grant_valid <= grant_valid_n;
            grant_id    <= grant_id_n;
            err_timeout <= err_n;
            cnt         <= cnt_n;
            last_q      <= last_n;
            in_burst    <= burst_n;
        end
    end

endmodule
